cache_controller: RTL

- 2-way set-associative read cache between the MEM stage and sram_controller.
- Read hits return data with zero latency.
- Read misses fetch a 64-bit line (two 32-bit words) through the SRAM controller and fill the LRU way.
- Writes are write-through and no-write-allocate: every write goes to SRAM, and the cache copy is updated on a hit. The MEM stage is stalled via ready while SRAM is busy.

---
 rtl/cache_controller_pkg.sv | 19 +
 rtl/cache_memory.sv | 77 +++++++
 rtl/cache_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// Shared constants for the 2-way read cache: geometry, address field positions and FSM encodings.
// Address layout: [2] word select, [8:3] set index, [18:9] tag.
package cache_controller_pkg;

  localparam int CACHE_SETS      = 64;
  localparam int CACHE_INDEX_LEN = 6;
  localparam int CACHE_TAG_LEN   = 10;

  localparam int ADDR_WSEL_BIT  = 2;
  localparam int ADDR_INDEX_LSB = 3;
  localparam int ADDR_TAG_LSB   = ADDR_INDEX_LSB + CACHE_INDEX_LEN;

  typedef enum logic [1:0] {
    CACHE_IDLE    = 2'd0,
    CACHE_RD_MISS = 2'd1,
    CACHE_WR      = 2'd2
  } cache_state_t;

endpackage

// File: rtl/cache_memory.sv
// Valid/tag/data/LRU storage for the 2-way cache: combinational lookup, synchronous updates.
// Only valid and LRU bits are reset; tag and data contents are qualified by valid.
module cache_memory #(
  parameter int SETS   = 64,
  parameter int TAG_W  = 10,
  parameter int WORD_W = 32,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    index,
  input  logic [TAG_W-1:0]    tag,
  output logic                hit0,
  output logic                hit1,
  output logic [2*WORD_W-1:0] line0,
  output logic [2*WORD_W-1:0] line1,
  output logic                lru,
  input  logic                fill_en,
  input  logic                fill_way,
  input  logic [2*WORD_W-1:0] fill_line,
  input  logic                word_en,
  input  logic                word_way,
  input  logic                word_sel,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                lru_en,
  input  logic                lru_val
);

  logic [SETS-1:0]     valid0;
  logic [SETS-1:0]     valid1;
  logic [SETS-1:0]     lru_bits;
  logic [TAG_W-1:0]    tag0  [SETS];
  logic [TAG_W-1:0]    tag1  [SETS];
  logic [2*WORD_W-1:0] data0 [SETS];
  logic [2*WORD_W-1:0] data1 [SETS];

  assign hit0  = valid0[index] && (tag0[index] == tag);
  assign hit1  = valid1[index] && (tag1[index] == tag);
  assign line0 = data0[index];
  assign line1 = data1[index];
  assign lru   = lru_bits[index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0   <= '0;
      valid1   <= '0;
      lru_bits <= '0;
    end else begin
      if (fill_en) begin
        if (fill_way) valid1[index] <= 1'b1;
        else          valid0[index] <= 1'b1;
      end
      if (lru_en) lru_bits[index] <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (fill_way) begin
        tag1[index]  <= tag;
        data1[index] <= fill_line;
      end else begin
        tag0[index]  <= tag;
        data0[index] <= fill_line;
      end
    end else if (word_en) begin
      if (word_way) begin
        if (word_sel) data1[index][2*WORD_W-1:WORD_W] <= word_data;
        else          data1[index][WORD_W-1:0]        <= word_data;
      end else begin
        if (word_sel) data0[index][2*WORD_W-1:WORD_W] <= word_data;
        else          data0[index][WORD_W-1:0]        <= word_data;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through/no-write-allocate read cache between MEM stage and SRAM.
// Hits answer in the same cycle; misses and all stores stall the requester through ready.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SETS   = CACHE_SETS,
  parameter int TAG_W  = CACHE_TAG_LEN,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [WORD_W-1:0]   wdata,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  output logic [WORD_W-1:0]   rdata,
  output logic                ready,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [WORD_W-1:0]   sram_wdata,
  output logic                sram_read,
  output logic                sram_write,
  input  logic [2*WORD_W-1:0] sram_rdata,
  input  logic                sram_ready
);

  localparam int IDX_W = $clog2(SETS);

  cache_state_t state, state_next;
  logic         settled;
  logic         complete;

  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic                wsel;
  logic                hit0, hit1, hit, hit_way, lru;
  logic [2*WORD_W-1:0] line0, line1, hit_line;
  logic [WORD_W-1:0]   hit_word, fill_word;
  logic                fill_en, word_en, lru_en, lru_val;

  assign index = address[ADDR_INDEX_LSB +: IDX_W];
  assign tag   = address[ADDR_TAG_LSB +: TAG_W];
  assign wsel  = address[ADDR_WSEL_BIT];

  // Way0 wins if both ways ever match.
  assign hit      = hit0 || hit1;
  assign hit_way  = !hit0;
  assign hit_line = hit0 ? line0 : line1;
  assign hit_word  = wsel ? hit_line[2*WORD_W-1:WORD_W]   : hit_line[WORD_W-1:0];
  assign fill_word = wsel ? sram_rdata[2*WORD_W-1:WORD_W] : sram_rdata[WORD_W-1:0];

  // sram_ready is stale on the first cycle of an access, so completion needs one settled cycle.
  assign complete = settled && sram_ready;

  cache_memory #(
    .SETS   (SETS),
    .TAG_W  (TAG_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .tag       (tag),
    .hit0      (hit0),
    .hit1      (hit1),
    .line0     (line0),
    .line1     (line1),
    .lru       (lru),
    .fill_en   (fill_en),
    .fill_way  (lru),
    .fill_line (sram_rdata),
    .word_en   (word_en),
    .word_way  (hit_way),
    .word_sel  (wsel),
    .word_data (wdata),
    .lru_en    (lru_en),
    .lru_val   (lru_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CACHE_IDLE;
      settled <= 1'b0;
    end else begin
      state   <= state_next;
      settled <= (state != CACHE_IDLE) && !complete;
    end
  end

  always_comb begin
    state_next   = state;
    ready        = 1'b0;
    rdata        = '0;
    sram_address = '0;
    sram_wdata   = '0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    fill_en      = 1'b0;
    word_en      = 1'b0;
    lru_en       = 1'b0;
    lru_val      = 1'b0;

    case (state)
      CACHE_IDLE: begin
        if (mem_w_en) begin
          state_next = CACHE_WR;
        end else if (mem_r_en) begin
          if (hit) begin
            ready   = 1'b1;
            rdata   = hit_word;
            lru_en  = 1'b1;
            lru_val = !hit_way;
          end else begin
            state_next = CACHE_RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      CACHE_RD_MISS: begin
        sram_read    = 1'b1;
        sram_address = {address[ADDR_W-1:3], 3'b000};
        if (complete) begin
          fill_en    = 1'b1;
          lru_en     = 1'b1;
          lru_val    = !lru;
          rdata      = fill_word;
          ready      = 1'b1;
          state_next = CACHE_IDLE;
        end
      end
      CACHE_WR: begin
        sram_write   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (complete) begin
          ready      = 1'b1;
          state_next = CACHE_IDLE;
          if (hit) begin
            word_en = 1'b1;
            lru_en  = 1'b1;
            lru_val = !hit_way;
          end
        end
      end
      default: state_next = CACHE_IDLE;
    endcase

    // Outputs must look idle for the whole time reset is held, whatever the requester drives.
    if (rst) begin
      ready      = 1'b1;
      rdata      = '0;
      sram_read  = 1'b0;
      sram_write = 1'b0;
      fill_en    = 1'b0;
      word_en    = 1'b0;
      lru_en     = 1'b0;
    end
  end

endmodule
